// File: rtl/wifi_phy_pkg.sv
// Shared constants, region type and lane classifier for the 802.11a/g RX
// descrambler slice.
//   SCR_*      : scrambler polynomial x^7 + x^4 + 1 (taps on state bits 6 and 3)
//   SVC_BITS   : SERVICE field length, SEED_BITS: SERVICE bits used for seed recovery
//   LEN_W      : width of the SIGNAL LENGTH field
//   region_e   : what a given bit position of the frame is
package wifi_phy_pkg;

    localparam logic [6:0] SCR_SEED  = 7'h7F;
    localparam int         SCR_TAP_A = 6;
    localparam int         SCR_TAP_B = 3;
    localparam int         SVC_BITS  = 16;
    localparam int         SEED_BITS = 7;
    localparam int         LEN_W     = 12;
    localparam int         CNT_W     = 16;

    typedef enum logic [1:0] {HDR, DATA, TAIL, PAD} region_e;

    // Region boundaries are exclusive end positions within the frame.
    function automatic region_e classify(input logic [16:0] idx,
                                         input logic [16:0] hdr_end,
                                         input logic [16:0] data_end,
                                         input logic [16:0] tail_end);
        region_e r;
        if (idx < hdr_end)       r = HDR;
        else if (idx < data_end) r = DATA;
        else if (idx < tail_end) r = TAIL;
        else                     r = PAD;
        return r;
    endfunction

endpackage

// File: rtl/wifi_descrambler_par_if.sv
// Bit-stream beat interface: W bits per beat, lane 0 is the earliest bit.
//   valid/data/last : driven by the producer (master)
//   ready           : driven by the consumer (slave)
// A beat transfers on a rising clock edge where valid and ready are both 1;
// the producer holds valid, data and last stable until that edge.
interface wifi_descrambler_par_if #(parameter int W = 1);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/wifi_scr_lfsr_step.sv
// Combinational W-lane unrolled descrambler LFSR.
//   state_in     : LFSR state before lane 0
//   rx           : received bits, lane 0 earliest
//   recover_mask : lane loads rx into the state (seed recovery), output 0
//   freeze_mask  : lane leaves the state untouched, output = rx
//   state_out    : LFSR state after the last lane
//   out_bits     : descrambled bits
// Lanes are chained so lane i sees the state left by lane i-1.
module wifi_scr_lfsr_step
    import wifi_phy_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [6:0]   state_in,
    input  logic [W-1:0] rx,
    input  logic [W-1:0] recover_mask,
    input  logic [W-1:0] freeze_mask,
    output logic [6:0]   state_out,
    output logic [W-1:0] out_bits
);

    logic [6:0] s;
    logic       fb;

    always_comb begin
        s        = state_in;
        fb       = 1'b0;
        out_bits = '0;
        for (int i = 0; i < W; i++) begin
            fb = s[SCR_TAP_A] ^ s[SCR_TAP_B];
            if (freeze_mask[i]) begin
                out_bits[i] = rx[i];
            end else if (recover_mask[i]) begin
                // Scrambled all-zero SERVICE bits equal the scrambler sequence.
                out_bits[i] = 1'b0;
                s           = {s[5:0], rx[i]};
            end else begin
                out_bits[i] = fb ^ rx[i];
                s           = {s[5:0], fb};
            end
        end
        state_out = s;
    end

endmodule

// File: rtl/wifi_descrambler_par.sv
// Parametrised 802.11a/g RX descrambler with valid/ready flow control.
// Passes the SIGNAL header, captures LENGTH and checks SIGNAL parity,
// descrambles SERVICE+PSDU, zeroes TAIL, passes pad bits unchanged.
//   clk, reset : clock, synchronous active-high reset
//   in_if      : received bit beats (slave side)
//   out_if     : processed bit beats, registered, 1-cycle latency (master side)
//   len_out    : captured LENGTH in octets, held after frame end
//   len_valid  : all 12 LENGTH bits of the current frame received
//   parity_err : sticky until frame end, even parity over SIGNAL bits 0..17 failed
module wifi_descrambler_par
    import wifi_phy_pkg::*;
#(
    parameter int W         = 1,
    parameter int HDR_BITS  = 24,
    parameter int LEN_LSB   = 5,
    parameter int TAIL_BITS = 6,
    parameter int SEED_MODE = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    wifi_descrambler_par_if.slave  in_if,
    wifi_descrambler_par_if.master out_if,
    output logic [LEN_W-1:0]     len_out,
    output logic                 len_valid,
    output logic                 parity_err
);

    // The parity bit sits directly after the LENGTH field.
    localparam int PAR_BIT = LEN_LSB + LEN_W;

    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       lfsr;
    logic [LEN_W-1:0] len_acc;
    logic             par_acc;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic             out_last;

    logic             in_ready;
    logic             accept;
    logic [16:0]      data_end;
    logic [16:0]      tail_end;
    logic [16:0]      idx [W];
    region_e          region [W];
    logic [W-1:0]     recover_mask;
    logic [W-1:0]     freeze_mask;
    logic [W-1:0]     step_out;
    logic [W-1:0]     lane_out;
    logic [6:0]       lfsr_next;
    logic [LEN_W-1:0] len_acc_next;
    logic             par_next;
    logic             len_done;
    logic             par_done;
    logic [16:0]      cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // Output register takes a new beat whenever it is empty or being drained.
    assign in_ready     = !out_valid || out_if.ready;
    assign accept       = in_if.valid && in_ready;
    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = out_data;
    assign out_if.last  = out_last;

    // Saturating frame bit counter.
    assign cnt_sum  = {1'b0, bit_cnt} + 17'(W);
    assign cnt_next = cnt_sum[16] ? '1 : cnt_sum[CNT_W-1:0];

    // Lane classification, LENGTH capture and parity accumulation.
    always_comb begin
        data_end     = 17'(HDR_BITS + SVC_BITS) + {2'b00, len_acc, 3'b000};
        tail_end     = data_end + 17'(TAIL_BITS);
        recover_mask = '0;
        freeze_mask  = '0;
        len_acc_next = len_acc;
        par_next     = par_acc;
        len_done     = 1'b0;
        par_done     = 1'b0;
        for (int i = 0; i < W; i++) begin
            idx[i]          = {1'b0, bit_cnt} + 17'(i);
            region[i]       = classify(idx[i], 17'(HDR_BITS), data_end, tail_end);
            freeze_mask[i]  = (region[i] != DATA);
            recover_mask[i] = (SEED_MODE != 0) && (region[i] == DATA) &&
                              (idx[i] < 17'(HDR_BITS + SEED_BITS));
            for (int j = 0; j < LEN_W; j++) begin
                if (idx[i] == 17'(LEN_LSB + j)) len_acc_next[j] = in_if.data[i];
            end
            if (idx[i] <= 17'(PAR_BIT)) par_next = par_next ^ in_if.data[i];
            if (idx[i] == 17'(LEN_LSB + LEN_W - 1)) len_done = 1'b1;
            if (idx[i] == 17'(PAR_BIT)) par_done = 1'b1;
        end
    end

    wifi_scr_lfsr_step #(.W(W)) u_step (
        .state_in     (lfsr),
        .rx           (in_if.data),
        .recover_mask (recover_mask),
        .freeze_mask  (freeze_mask),
        .state_out    (lfsr_next),
        .out_bits     (step_out)
    );

    always_comb begin
        lane_out = '0;
        for (int i = 0; i < W; i++) begin
            case (region[i])
                HDR, PAD: lane_out[i] = in_if.data[i];
                DATA:     lane_out[i] = step_out[i];
                default:  lane_out[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            len_out    <= '0;
            len_valid  <= 1'b0;
            parity_err <= 1'b0;
            lfsr       <= SCR_SEED;
            bit_cnt    <= '0;
            len_acc    <= '0;
            par_acc    <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= lane_out;
            out_last  <= in_if.last;
            if (in_if.last) begin
                // Frame end (complete or truncated): rearm for the next frame.
                bit_cnt    <= '0;
                lfsr       <= SCR_SEED;
                len_valid  <= 1'b0;
                parity_err <= 1'b0;
                par_acc    <= 1'b0;
            end else begin
                bit_cnt <= cnt_next;
                lfsr    <= lfsr_next;
                len_acc <= len_acc_next;
                par_acc <= par_next;
                if (len_done) begin
                    len_out   <= len_acc_next;
                    len_valid <= 1'b1;
                end
                if (par_done && par_next) parity_err <= 1'b1;
            end
        end else if (out_if.ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wifi_descrambler_par.sv
// Bench for wifi_descrambler_par: four instances (W=1 fixed seed, W=1 seed
// recovery, W=4 and W=8 seed recovery). Frames come from a transmit-side
// scrambler model; expected beats are queued on acceptance and compared
// as the DUT emits them.
module tb_wifi_descrambler_par;

    localparam int NDUT = 4;
    localparam int MAXB = 512;
    localparam int NV   = 9;

    logic clk;
    logic reset;

    logic [NDUT-1:0]       in_valid_v;
    logic [NDUT-1:0][7:0]  in_data_v;
    logic [NDUT-1:0]       in_last_v;
    logic [NDUT-1:0]       in_ready_v;
    logic [NDUT-1:0]       out_ready_v;
    logic [NDUT-1:0]       out_valid_v;
    logic [NDUT-1:0][7:0]  out_data_v;
    logic [NDUT-1:0]       out_last_v;
    logic [NDUT-1:0][11:0] len_out_v;
    logic [NDUT-1:0]       len_valid_v;
    logic [NDUT-1:0]       parity_err_v;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int GW = (g < 2) ? 1 : ((g == 2) ? 4 : 8);
        localparam int GS = (g == 0) ? 0 : 1;
        wifi_descrambler_par_if #(.W(GW)) in_if ();
        wifi_descrambler_par_if #(.W(GW)) out_if ();
        assign in_if.valid    = in_valid_v[g];
        assign in_if.data     = in_data_v[g][GW-1:0];
        assign in_if.last     = in_last_v[g];
        assign in_ready_v[g]  = in_if.ready;
        assign out_if.ready   = out_ready_v[g];
        assign out_valid_v[g] = out_if.valid;
        assign out_data_v[g]  = 8'(out_if.data);
        assign out_last_v[g]  = out_if.last;
        wifi_descrambler_par #(.W(GW), .HDR_BITS(24), .LEN_LSB(5), .TAIL_BITS(6),
                               .SEED_MODE(GS)) dut (
            .clk        (clk),
            .reset      (reset),
            .in_if      (in_if),
            .out_if     (out_if),
            .len_out    (len_out_v[g]),
            .len_valid  (len_valid_v[g]),
            .parity_err (parity_err_v[g])
        );
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cur     = 0;
    bit         mon_en  = 1'b0;
    bit         stall_en = 1'b0;
    logic [8:0] exp_q[$];
    logic       rx_bits  [MAXB];
    logic       exp_bits [MAXB];
    int         nbits;

    typedef struct {
        int         k;
        int         len;
        logic [6:0] seed;
        logic [7:0] psdu0;
        bit         flip;
        bit         stall;
        int         exp_len;
        bit         exp_par;
    } vec_t;
    vec_t vecs [NV];

    function automatic int dut_w(input int k);
        return (k < 2) ? 1 : ((k == 2) ? 4 : 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transmit side: SIGNAL, then SERVICE(0)+PSDU scrambled from seed, zero
    // tail, random pad. Expected stream is the unscrambled frame.
    task automatic build_frame(input int len, input logic [6:0] seed,
                               input logic [7:0] psdu0, input bit flip);
        logic [23:0] sig;
        logic [6:0]  s;
        logic        d;
        logic        fb;
        int          n;
        sig        = '0;
        sig[3:0]   = 4'b1011;
        sig[16:5]  = 12'(len);
        sig[17]    = (^sig[16:0]) ^ flip;
        for (int i = 0; i < 24; i++) begin
            rx_bits[i]  = sig[i];
            exp_bits[i] = sig[i];
        end
        n = 24;
        s = seed;
        for (int j = 0; j < 16 + 8 * len; j++) begin
            if (j < 16)      d = 1'b0;
            else if (j < 24) d = psdu0[j-16];
            else             d = 1'($urandom_range(0, 1));
            fb          = s[6] ^ s[3];
            rx_bits[n]  = d ^ fb;
            exp_bits[n] = d;
            s           = {s[5:0], fb};
            n++;
        end
        for (int j = 0; j < 6; j++) begin
            rx_bits[n]  = 1'b0;
            exp_bits[n] = 1'b0;
            n++;
        end
        for (int j = 0; j < 10; j++) begin
            d           = 1'($urandom_range(0, 1));
            rx_bits[n]  = d;
            exp_bits[n] = d;
            n++;
        end
        nbits = n;
    endtask

    // ---------------- driver ----------------
    task automatic drive_beat(input int k, input int b, input int nbeats, input bit gaps);
        int         w;
        int         t;
        logic [7:0] d;
        logic [7:0] e;
        logic       l;
        w = dut_w(k);
        d = '0;
        e = '0;
        for (int i = 0; i < w; i++) begin
            d[i] = rx_bits[b*w+i];
            e[i] = exp_bits[b*w+i];
        end
        l = (b == nbeats - 1);
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
        in_valid_v[k] = 1'b1;
        in_data_v[k]  = d;
        in_last_v[k]  = l;
        t = 0;
        @(negedge clk);
        while (!in_ready_v[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready_v[k]) check("in_ready_timeout", 32'(t), 0);
        else exp_q.push_back({l, e});
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        in_last_v[k]  = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 0);
    endtask

    task automatic send_frame(input int k, input int nbeats, input bit gaps,
                              input int exp_len, input bit exp_par);
        int w;
        w   = dut_w(k);
        cur = k;
        for (int b = 0; b < nbeats; b++) begin
            drive_beat(k, b, nbeats, gaps);
            if (b == 23 / w) begin
                check("hdr_len_valid", 32'(len_valid_v[k]), 1);
                check("hdr_len_out", 32'(len_out_v[k]), 32'(exp_len));
                check("hdr_parity_err", 32'(parity_err_v[k]), 32'(exp_par));
            end
        end
        drain();
        check("end_len_valid", 32'(len_valid_v[k]), 0);
        check("end_parity_err", 32'(parity_err_v[k]), 0);
        check("end_len_out", 32'(len_out_v[k]), 32'(exp_len));
        check("end_out_valid", 32'(out_valid_v[k]), 0);
    endtask

    // ---------------- sink readiness ----------------
    initial begin
        out_ready_v = '1;
        forever begin
            @(posedge clk);
            #1;
            out_ready_v = stall_en ? 4'($urandom_range(0, 15)) : '1;
        end
    end

    // ---------------- scoreboard ----------------
    logic       hold_valid = 1'b0;
    logic [8:0] hold_word;
    logic [8:0] got_e;

    always @(negedge clk) begin
        if (reset || !mon_en) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid)
                check("stall_hold", {out_valid_v[cur], out_last_v[cur], out_data_v[cur]},
                      {1'b1, hold_word});
            hold_valid = out_valid_v[cur] && !out_ready_v[cur];
            hold_word  = {out_last_v[cur], out_data_v[cur]};
            if (out_valid_v[cur] && out_ready_v[cur]) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(exp_q.size()), 1);
                end else begin
                    got_e = exp_q.pop_front();
                    check("beat", {out_last_v[cur], out_data_v[cur]}, got_e);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        reset      = 1'b1;
        in_valid_v = '0;
        in_data_v  = '0;
        in_last_v  = '0;

        //           k  len seed   psdu0  flip stall exp_len exp_par
        vecs[0] = '{0, 1, 7'h7F, 8'hA5, 0, 0, 1, 0};
        vecs[1] = '{1, 4, 7'h5D, 8'h3C, 0, 0, 4, 0};
        vecs[2] = '{2, 4, 7'h5D, 8'h3C, 0, 0, 4, 0};
        vecs[3] = '{3, 4, 7'h5D, 8'h3C, 0, 0, 4, 0};
        vecs[4] = '{1, 3, 7'h2A, 8'hF0, 0, 1, 3, 0};
        vecs[5] = '{3, 7, 7'h11, 8'h81, 0, 1, 7, 0};
        vecs[6] = '{0, 2, 7'h7F, 8'h5A, 1, 0, 2, 1};
        vecs[7] = '{0, 2, 7'h7F, 8'hC3, 0, 0, 2, 0};
        vecs[8] = '{2, 0, 7'h3C, 8'h00, 0, 1, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++)
            check("reset_state",
                  {out_valid_v[k], out_last_v[k], out_data_v[k], len_valid_v[k],
                   parity_err_v[k], len_out_v[k], in_ready_v[k]},
                  {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000, 1'b1});
        reset  = 1'b0;
        mon_en = 1'b1;

        for (int v = 0; v < NV; v++) begin
            stall_en = vecs[v].stall;
            build_frame(vecs[v].len, vecs[v].seed, vecs[v].psdu0, vecs[v].flip);
            send_frame(vecs[v].k, nbits / dut_w(vecs[v].k), vecs[v].stall,
                       vecs[v].exp_len, vecs[v].exp_par);
        end
        stall_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Parity flag rises exactly with SIGNAL bit 17 and clears at frame end.
        cur = 0;
        build_frame(2, 7'h7F, 8'h99, 1'b1);
        for (int b = 0; b < 17; b++) drive_beat(0, b, nbits, 1'b0);
        check("par_before_bit17", 32'(parity_err_v[0]), 0);
        drive_beat(0, 17, nbits, 1'b0);
        check("par_at_bit17", 32'(parity_err_v[0]), 1);
        check("len_valid_at_bit17", 32'(len_valid_v[0]), 1);
        for (int b = 18; b < nbits; b++) drive_beat(0, b, nbits, 1'b0);
        drain();
        check("par_cleared", 32'(parity_err_v[0]), 0);

        // Truncated frame ending at bit 40, then a complete frame.
        build_frame(3, 7'h7F, 8'h66, 1'b0);
        send_frame(0, 41, 1'b0, 3, 1'b0);
        build_frame(2, 7'h7F, 8'h0F, 1'b0);
        send_frame(0, nbits, 1'b0, 2, 1'b0);

        // Reset in the middle of the PSDU discards the in-flight beat.
        build_frame(2, 7'h7F, 8'hE7, 1'b0);
        for (int b = 0; b < 45; b++) drive_beat(0, b, nbits, 1'b0);
        check("len_before_reset", 32'(len_out_v[0]), 2);
        mon_en = 1'b0;
        reset  = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_mid_frame",
              {out_valid_v[0], out_last_v[0], out_data_v[0], len_valid_v[0],
               parity_err_v[0], len_out_v[0]},
              {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 12'h000});
        mon_en = 1'b1;

        // Next frame decodes cleanly; first beat appears one cycle after accept.
        build_frame(1, 7'h7F, 8'hA5, 1'b0);
        drive_beat(0, 0, nbits, 1'b0);
        check("latency_valid", 32'(out_valid_v[0]), 1);
        check("latency_data", 32'(out_data_v[0]), 32'(exp_bits[0]));
        for (int b = 1; b < nbits; b++) drive_beat(0, b, nbits, 1'b0);
        drain();
        check("after_reset_len", 32'(len_out_v[0]), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
